// File: rtl/logic_bist_checker.sv
// Logic BIST checker: sweeps every {a,b} operand pair into an N-bit OR unit,
// waits LATENCY cycles for the result and counts/locates mismatches.
module logic_bist_checker #(
   parameter int unsigned N           = 4,
   parameter int unsigned NUM_VECTORS = 256,
   parameter int unsigned LATENCY     = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   output logic [N-1:0]  a_out,
   output logic [N-1:0]  b_out,
   input  logic [N-1:0]  result_in,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [15:0]   err_count,
   output logic [15:0]   first_fail_vec
);

   localparam int unsigned IW = 16;
   localparam int unsigned CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VECTORS - 1);
   localparam logic [CW-1:0] LAT_LOAD = CW'(LATENCY);
   localparam logic [15:0]   NO_FAIL  = 16'hFFFF;
   localparam logic [15:0]   ERR_MAX  = 16'hFFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [15:0]     err_q, err_d;
   logic [15:0]     ffv_q, ffv_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ffv_d   = ffv_q;

      if (abort) begin
         state_d = S_IDLE;
         idx_d   = '0;
         a_d     = '0;
         b_d     = '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  idx_d   = '0;
                  err_d   = '0;
                  ffv_d   = NO_FAIL;
                  state_d = S_DRIVE;
               end
            end
            S_DRIVE: begin
               a_d     = idx_q[2*N-1:N];
               b_d     = idx_q[N-1:0];
               cnt_d   = LAT_LOAD;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = S_CHECK;
               end
            end
            S_CHECK: begin
               if (result_in != (a_q | b_q)) begin
                  if (err_q != ERR_MAX) begin
                     err_d = err_q + 16'd1;
                  end
                  if (ffv_q == NO_FAIL) begin
                     ffv_d = idx_q;
                  end
               end
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = S_DRIVE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d == S_DRIVE) || (state_d == S_WAIT) || (state_d == S_CHECK);
      done_d = (state_d == S_DONE);
      pass_d = done_d && (err_d == 16'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         ffv_q   <= NO_FAIL;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ffv_q   <= ffv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign a_out          = a_q;
   assign b_out          = b_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_logic_bist_checker.sv
// Directed bench for logic_bist_checker: table of full runs plus abort, reset,
// and LATENCY=3 sequences with hand-computed expectations.
module tb_logic_bist_checker;

   localparam int unsigned N = 4;

   logic          clk;
   logic          rst;
   logic          start;
   logic          abort;
   logic [N-1:0]  a_out, b_out, result_in;
   logic          busy, done, pass;
   logic [15:0]   err_count, first_fail_vec;
   logic          fault;

   logic          start2;
   logic [N-1:0]  a2, b2, res2;
   logic          busy2, done2, pass2;
   logic [15:0]   err2, ffv2;
   logic [N-1:0]  p0, p1, p2;

   int checks = 0;
   int errors = 0;

   logic_bist_checker #(.N(N), .NUM_VECTORS(256), .LATENCY(1)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .a_out(a_out), .b_out(b_out), .result_in(result_in),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_fail_vec(first_fail_vec)
   );

   logic_bist_checker #(.N(N), .NUM_VECTORS(256), .LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
      .a_out(a2), .b_out(b2), .result_in(res2),
      .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .first_fail_vec(ffv2)
   );

   // Unit model: OR gate, optionally with result bit 0 stuck at 0
   always_comb begin
      result_in = a_out | b_out;
      if (fault) result_in[0] = 1'b0;
   end

   // Three-cycle delayed OR unit for the LATENCY=3 instance
   always @(posedge clk) begin
      p0 <= a2 | b2;
      p1 <= p0;
      p2 <= p1;
   end
   assign res2 = p2;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        fault;
      logic        pulse_mid;
      logic [15:0] exp_err;
      logic [15:0] exp_ffv;
      logic        exp_pass;
   } vec_t;

   vec_t tbl[3];
   int   n;
   logic seen;

   initial begin
      clk = 0; rst = 1; start = 0; abort = 0; fault = 0; start2 = 0;
      p0 = '0; p1 = '0; p2 = '0;
      #3 rst = 0;
      #9;
      chk("rst_a", 16'(a_out), 16'h0);
      chk("rst_b", 16'(b_out), 16'h0);
      chk("rst_busy_done_pass", {13'h0, busy, done, pass}, 16'h0);
      chk("rst_err", err_count, 16'h0);
      chk("rst_ffv", first_fail_vec, 16'hFFFF);
      @(negedge clk) rst = 1;
      @(negedge clk);

      tbl[0] = '{fault: 1'b0, pulse_mid: 1'b1, exp_err: 16'd0,   exp_ffv: 16'hFFFF, exp_pass: 1'b1};
      tbl[1] = '{fault: 1'b1, pulse_mid: 1'b0, exp_err: 16'd192, exp_ffv: 16'd1,    exp_pass: 1'b0};
      tbl[2] = '{fault: 1'b0, pulse_mid: 1'b0, exp_err: 16'd0,   exp_ffv: 16'hFFFF, exp_pass: 1'b1};

      for (int i = 0; i < 3; i++) begin
         fault = tbl[i].fault;
         start = 1;
         @(negedge clk);
         start = 0;
         n = 1;
         chk("start_err_clear", err_count, 16'h0);
         chk("start_ffv_clear", first_fail_vec, 16'hFFFF);
         chk("start_busy_done", {14'h0, busy, done}, 16'h2);
         while (!done && n < 2000) begin
            start = tbl[i].pulse_mid && (n == 100);
            @(negedge clk);
            n++;
         end
         start = 0;
         chk("run_latency", 16'(n), 16'd769);
         chk("run_err", err_count, tbl[i].exp_err);
         chk("run_ffv", first_fail_vec, tbl[i].exp_ffv);
         chk("run_pass", {15'h0, pass}, {15'h0, tbl[i].exp_pass});
         chk("run_busy", {15'h0, busy}, 16'h0);
         chk("run_last_ab", {8'h0, a_out, b_out}, 16'h00FF);
         repeat (5) @(negedge clk);
         chk("done_hold", {14'h0, done, pass}, {14'h0, 1'b1, tbl[i].exp_pass});
         chk("done_hold_err", err_count, tbl[i].exp_err);
      end

      // Abort during vector 10 of a failing run: counters kept, outputs idle
      fault = 1;
      start = 1;
      @(negedge clk);
      start = 0;
      n = 0;
      while (!(busy && a_out == 4'h0 && b_out == 4'hA) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reach_vec10", {15'h0, n < 200}, 16'h1);
      abort = 1;
      @(negedge clk);
      abort = 0;
      chk("abort_idle", {13'h0, busy, done, pass}, 16'h0);
      chk("abort_ab", {8'h0, a_out, b_out}, 16'h0);
      chk("abort_err_kept", err_count, 16'd5);
      chk("abort_ffv_kept", first_fail_vec, 16'd1);
      repeat (4) @(negedge clk);
      chk("abort_stays_idle", {14'h0, busy, done}, 16'h0);
      fault = 0;
      start = 1;
      @(negedge clk);
      start = 0;
      n = 1;
      while (!done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("rerun_latency", 16'(n), 16'd769);
      chk("rerun_pass", {15'h0, pass}, 16'h1);
      chk("rerun_err", err_count, 16'h0);

      // Asynchronous reset mid-WAIT of vector 6 in a failing run
      fault = 1;
      start = 1;
      @(negedge clk);
      start = 0;
      n = 0;
      while (!(busy && a_out == 4'h0 && b_out == 4'h6) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_err_before", err_count, 16'd3);
      #2 rst = 0;
      #1;
      chk("rst_mid_ab", {8'h0, a_out, b_out}, 16'h0);
      chk("rst_mid_flags", {13'h0, busy, done, pass}, 16'h0);
      chk("rst_mid_err", err_count, 16'h0);
      chk("rst_mid_ffv", first_fail_vec, 16'hFFFF);
      @(negedge clk) rst = 1;
      fault = 0;
      seen = 0;
      repeat (800) begin
         @(negedge clk);
         if (done || busy) seen = 1;
      end
      chk("rst_no_restart", {15'h0, seen}, 16'h0);

      // LATENCY=3 instance with a three-cycle delayed unit
      start2 = 1;
      @(negedge clk);
      start2 = 0;
      n = 1;
      while (!done2 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("lat3_latency", 16'(n), 16'd1281);
      chk("lat3_pass", {15'h0, pass2}, 16'h1);
      chk("lat3_err", err2, 16'h0);
      chk("lat3_ffv", ffv2, 16'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/logic_bist_checker.md
LOGIC_BIST_CHECKER -- requirements
Module: logic_bist_checker

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning operand width of the bitwise unit under test; 1 <= N <= 8.
REQ-002 The module SHALL have parameter NUM_VECTORS, default 256, meaning vectors applied per run; 1 <= NUM_VECTORS <= 2^(2N).
REQ-003 The module SHALL have parameter LATENCY, default 1, meaning cycles allowed for the unit's result to settle; LATENCY >= 1.
REQ-004 The module SHALL have port clk, input, 1, meaning single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1, meaning reset, asynchronous assert, active-low.
REQ-006 The module SHALL have port start, input, 1, meaning run request, sampled in IDLE or DONE.
REQ-007 The module SHALL have port abort, input, 1, meaning cancel run, any state.
REQ-008 The module SHALL have port a_out, output, N, meaning operand a driven to unit.
REQ-009 The module SHALL have port b_out, output, N, meaning operand b driven to unit.
REQ-010 The module SHALL have port result_in, input, N, meaning unit output under check.
REQ-011 The module SHALL have port busy, output, 1, meaning high in DRIVE, WAIT and CHECK.
REQ-012 The module SHALL have port done, output, 1, meaning high in DONE only.
REQ-013 The module SHALL have port pass, output, 1, meaning high in DONE when err_count == 0, else 0.
REQ-014 The module SHALL have port err_count, output, 16, meaning mismatch count, saturating at 16'hFFFF.
REQ-015 The module SHALL have port first_fail_vec, output, 16, meaning index of first mismatching vector; 16'hFFFF when no mismatch has occurred.

Function
REQ-016 The module SHALL implement FSM states IDLE, DRIVE, WAIT, CHECK, DONE.
REQ-017 The module SHALL keep a 16-bit vector index idx; vector k SHALL drive a_out = k[2N-1:N] and b_out = k[N-1:0].
REQ-018 In IDLE, when start = 1, the module SHALL clear idx, err_count to 0 and first_fail_vec to 16'hFFFF, then go to DRIVE.
REQ-019 DRIVE SHALL register a_out and b_out from idx, last 1 cycle, load the wait counter with LATENCY and go to WAIT.
REQ-020 WAIT SHALL last exactly LATENCY cycles, then go to CHECK; a_out and b_out SHALL be held stable throughout WAIT.
REQ-021 In CHECK, the module SHALL compare result_in with (a_out | b_out); on mismatch, it SHALL increment err_count (saturating) and, if first_fail_vec == 16'hFFFF, load idx into first_fail_vec.
REQ-022 In CHECK, when idx == NUM_VECTORS-1 the module SHALL go to DONE; otherwise it SHALL increment idx and go to DRIVE.
REQ-023 Each vector SHALL take LATENCY+2 cycles; with start sampled in cycle t, done SHALL first be 1 in cycle t+1+NUM_VECTORS*(LATENCY+2).
REQ-024 DONE SHALL hold err_count, first_fail_vec, pass and the last a_out/b_out until start (restart per REQ-018, same transition as IDLE) or abort.
REQ-025 start while busy = 1 SHALL be ignored.
REQ-026 abort = 1 in any state SHALL move to IDLE next edge and take priority over start; err_count and first_fail_vec SHALL retain their values; done and pass SHALL be 0.
REQ-027 In IDLE, a_out, b_out, busy, done and pass SHALL be 0.

Reset
REQ-028 When rst = 0, the module SHALL immediately, independent of clk, set state to IDLE; idx, a_out, b_out, busy, done, pass and err_count to 0; and first_fail_vec to 16'hFFFF.
REQ-029 Reset asserted mid-run SHALL discard the run; after rst rises, a new run SHALL need a fresh start.

Verification
REQ-030 Defaults with correct unit (result_in = a_out | b_out): start at cycle t -> done = 1 at t+769, pass = 1, err_count = 0, first_fail_vec = 16'hFFFF.
REQ-031 Unit with result bit 0 stuck at 0: full run -> err_count = 192, first_fail_vec = 1 (a = 4'b0000, b = 4'b0001), pass = 0.
REQ-032 Correct unit, abort during vector 10 -> IDLE next edge, busy = 0, done = 0, a_out = b_out = 0; next start -> idx restarts at 0 and reaches pass = 1.
REQ-033 rst driven low mid-WAIT between clock edges -> outputs take reset values before the next edge; no done without new start.
REQ-034 start pulsed during busy -> no effect, done timing unchanged; start in DONE after a failing run -> err_count clears to 0, first_fail_vec to 16'hFFFF, new run begins.
REQ-035 LATENCY = 3 with a unit result delayed 3 cycles: run -> pass = 1, done at t+1+256*5 = t+1281.
